crop_frame_sched: RTL and testbench
===================================

// Module: crop_frame_sched
// PURPOSE
//  Per-frame scheduler for the crop/normalise datapath (crop_norm). Sits beside it in CustomLogic.
//  Arms it with ap_start once per frame and latches/clamps the crop box at frame boundaries.
//  Tracks raster position (cnt_col/cnt_row) from the observed pixel handshake.
//  Waits for ap_done with a timeout watchdog, and reports frame count and sticky errors.
// PARAMETERS
//  IN_ROWS       1024   full-frame rows
//  IN_COLS       1024   full-frame cols
//  OUT_ROWS      64     crop-box rows; must be <= IN_ROWS
//  OUT_COLS      64     crop-box cols; must be <= IN_COLS
//  DONE_TIMEOUT  4096   max cycles in DRAIN waiting for ap_done; must be >= 1
// PORTS
//  clk            in   1             single clock domain
//  srst           in   1             synchronous reset, active-high
//  enable         in   1             1 = free-run frame after frame; 0 = stop after current frame
//  cfg_x0         in   clog2(IN_COLS) requested crop left edge
//  cfg_y0         in   clog2(IN_ROWS) requested crop top edge
//  cfg_valid      in   1             1-cycle strobe: capture cfg_x0/y0 into pending regs
//  seq_ap_idle    in   1             upstream sequentializer idle
//  pix_tvalid     in   1             observed tvalid on the crop_norm slave stream
//  pix_tready     in   1             observed tready on the crop_norm slave stream
//  cn_ap_ready    in   1             crop_norm ap_ready
//  cn_ap_done     in   1             crop_norm ap_done
//  cn_ap_start    out  1             crop_norm ap_start
//  crop_x0        out  clog2(IN_COLS) active crop left edge (stable for a whole frame)
//  crop_y0        out  clog2(IN_ROWS) active crop top edge (stable for a whole frame)
//  cnt_col        out  clog2(IN_COLS) column index of the next accepted beat
//  cnt_row        out  clog2(IN_ROWS) row index of the next accepted beat
//  frame_active   out  1             high in RUN and DRAIN
//  frame_count    out  16            frames completed; wraps 0xFFFF->0
//  err_clamped    out  1             sticky: a cfg was clamped into range
//  err_overrun    out  1             sticky: beat accepted while not in RUN
//  err_timeout    out  1             sticky: DRAIN watchdog expired
// BEHAVIOUR
//  Reset values:
//   - All outputs 0; state IDLE; pending and active crop regs 0; watchdog 0.
//   - srst mid-frame aborts immediately; no ap_start is issued in the reset cycle.
//  Clamp on cfg_valid:
//   - pending_x0 = min(cfg_x0, IN_COLS-OUT_COLS); likewise y0 with IN_ROWS-OUT_ROWS.
//   - Any clamp sets err_clamped. Allowed in any state; never touches crop_x0/y0 mid-frame.
//  FSM:
//   - IDLE:  enable=1 && seq_ap_idle=1 -> ARM.
//   - ARM:   cn_ap_start=1; held until cn_ap_ready=1 is sampled (start handshake).
//            Same cycle: crop_x0/y0 <= pending; go to RUN.
//            If enable drops in ARM, stay in ARM until the handshake (no start withdrawn).
//   - RUN:   beat = pix_tvalid && pix_tready.
//            Per beat: cnt_col++; at IN_COLS-1 wrap to 0 and cnt_row++.
//            Beat at (IN_ROWS-1, IN_COLS-1): counters -> 0, go to DRAIN.
//   - DRAIN: watchdog++ each cycle.
//            cn_ap_done=1 -> frame_count++, watchdog=0, next = enable ? ARM : IDLE.
//            watchdog==DONE_TIMEOUT-1 without done -> err_timeout=1, counters 0, go to IDLE.
//   - cn_ap_done seen outside DRAIN is ignored.
//  Edge cases:
//   - Beat in IDLE/ARM/DRAIN sets err_overrun; counters do not move.
//   - cfg_valid and ARM->RUN in the same cycle: the old pending value is loaded; the new one
//     applies next frame.
//   - IN_COLS=1: every beat advances the row.
//  Outputs and latency:
//   - All outputs are registered; counters update the cycle after the beat.
//   - cn_ap_start rises 1 cycle after entering ARM-eligible conditions.
// STRUCTURE
//  - crop_sched_pkg: state_t enum {IDLE,ARM,RUN,DRAIN}; localparams COL_W/ROW_W = $clog2 widths;
//    function clamp_coord().
//  - Sub-module frame_pos_counter: beat-driven col/row raster counter with wrap and last-pixel
//    flag; reused by other stream blocks.
// TESTING
//  - Reset/IDLE: srst 3 cycles, enable=0, pix beats -> outputs 0, err_overrun=1, counters stay 0.
//  - Single frame:
//      IN 8x8, OUT 4x4, cfg (2,3), enable 1 then 0 after ARM; 64 beats with random tvalid gaps;
//      ap_done 5 cycles later.
//      -> crop (2,3) latched at handshake; cnt_row/col follow the raster and end at 0;
//         frame_count=1; IDLE.
//  - Clamp: cfg_x0=7 with IN_COLS=8, OUT_COLS=4 -> crop_x0=4, err_clamped=1.
//  - Mid-frame reconfig: cfg (1,1) after beat 10 of frame 0 -> frame 0 keeps old crop;
//    frame 1 uses (1,1).
//  - Timeout: DONE_TIMEOUT=16, no ap_done -> err_timeout rises exactly 16 cycles after entering
//    DRAIN, state IDLE.
//  - srst asserted at beat 30 -> next cycle all outputs 0; restart gives a clean frame.

Source files
------------

// File: rtl/crop_sched_pkg.sv
// Shared types and helpers for the crop/normalise frame scheduler.
package crop_sched_pkg;

    // Scheduler states: wait for go, hold ap_start, count the frame, wait for ap_done
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARM   = 2'd1,
        RUN   = 2'd2,
        DRAIN = 2'd3
    } state_t;

    // Coordinate widths for the default 1024x1024 frame
    localparam int COL_W = $clog2(1024);
    localparam int ROW_W = $clog2(1024);

    // Width of a counter spanning 0..n-1, never narrower than one bit
    function automatic int coord_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Limit a requested coordinate so the crop box stays inside the frame
    function automatic logic [31:0] clamp_coord(input logic [31:0] req, input logic [31:0] lim);
        return (req > lim) ? lim : req;
    endfunction

endpackage

// File: rtl/crop_frame_sched_pos.sv
// Beat-driven raster position counter (column then row) with a last-pixel flag.
module frame_pos_counter
    import crop_sched_pkg::*;
#(
    parameter  int COLS = 1024,
    parameter  int ROWS = 1024,
    localparam int CW   = coord_w(COLS),
    localparam int RW   = coord_w(ROWS)
) (
    input  logic          clk,
    input  logic          srst,
    input  logic          clear_i,
    input  logic          adv_i,
    output logic [CW-1:0] col_o,
    output logic [RW-1:0] row_o,
    output logic          last_o
);

    logic [CW-1:0] col_q;
    logic [RW-1:0] row_q;
    logic          colLast;
    logic          rowLast;

    assign colLast = (col_q == CW'(COLS - 1));
    assign rowLast = (row_q == RW'(ROWS - 1));

    // Step the raster position on each accepted beat, wrapping at the line and frame ends
    always_ff @(posedge clk) begin
        if (srst || clear_i) begin
            col_q <= '0;
            row_q <= '0;
        end else if (adv_i) begin
            if (colLast) begin
                col_q <= '0;
                row_q <= rowLast ? '0 : row_q + RW'(1);
            end else begin
                col_q <= col_q + CW'(1);
            end
        end
    end

    assign col_o  = col_q;
    assign row_o  = row_q;
    assign last_o = colLast && rowLast;

endmodule

// File: rtl/crop_frame_sched.sv
// Per-frame scheduler for crop_norm: arms ap_start, latches the crop box at frame
// boundaries, tracks raster position and watches for ap_done with a timeout.
module crop_frame_sched
    import crop_sched_pkg::*;
#(
    parameter  int IN_ROWS      = 1024,
    parameter  int IN_COLS      = 1024,
    parameter  int OUT_ROWS     = 64,
    parameter  int OUT_COLS     = 64,
    parameter  int DONE_TIMEOUT = 4096,
    localparam int XW           = coord_w(IN_COLS),
    localparam int YW           = coord_w(IN_ROWS)
) (
    input  logic          clk,
    input  logic          srst,
    input  logic          enable,
    input  logic [XW-1:0] cfg_x0,
    input  logic [YW-1:0] cfg_y0,
    input  logic          cfg_valid,
    input  logic          seq_ap_idle,
    input  logic          pix_tvalid,
    input  logic          pix_tready,
    input  logic          cn_ap_ready,
    input  logic          cn_ap_done,
    output logic          cn_ap_start,
    output logic [XW-1:0] crop_x0,
    output logic [YW-1:0] crop_y0,
    output logic [XW-1:0] cnt_col,
    output logic [YW-1:0] cnt_row,
    output logic          frame_active,
    output logic [15:0]   frame_count,
    output logic          err_clamped,
    output logic          err_overrun,
    output logic          err_timeout
);

    localparam int          WDW   = coord_w(DONE_TIMEOUT);
    localparam logic [31:0] X_LIM = 32'(IN_COLS - OUT_COLS);
    localparam logic [31:0] Y_LIM = 32'(IN_ROWS - OUT_ROWS);

    state_t         state_q;
    logic           start_q;
    logic           active_q;
    logic [XW-1:0]  pendX0_q;
    logic [YW-1:0]  pendY0_q;
    logic [XW-1:0]  cropX0_q;
    logic [YW-1:0]  cropY0_q;
    logic [15:0]    frameCount_q;
    logic [WDW-1:0] wd_q;
    logic           errClamped_q;
    logic           errOverrun_q;
    logic           errTimeout_q;

    logic           beat;
    logic           posAdv;
    logic           posLast;
    logic           wdExpire;

    assign beat     = pix_tvalid && pix_tready;
    assign posAdv   = beat && (state_q == RUN);
    assign wdExpire = (state_q == DRAIN) && !cn_ap_done && (wd_q == WDW'(DONE_TIMEOUT - 1));

    frame_pos_counter #(
        .COLS (IN_COLS),
        .ROWS (IN_ROWS)
    ) u_pos (
        .clk     (clk),
        .srst    (srst),
        .clear_i (wdExpire),
        .adv_i   (posAdv),
        .col_o   (cnt_col),
        .row_o   (cnt_row),
        .last_o  (posLast)
    );

    // Capture and clamp a requested crop origin into the pending registers
    always_ff @(posedge clk) begin
        if (srst) begin
            pendX0_q     <= '0;
            pendY0_q     <= '0;
            errClamped_q <= 1'b0;
        end else if (cfg_valid) begin
            pendX0_q <= XW'(clamp_coord(32'(cfg_x0), X_LIM));
            pendY0_q <= YW'(clamp_coord(32'(cfg_y0), Y_LIM));
            if ((32'(cfg_x0) > X_LIM) || (32'(cfg_y0) > Y_LIM)) begin
                errClamped_q <= 1'b1;
            end
        end
    end

    // Flag any beat the datapath accepts while no frame is being counted
    always_ff @(posedge clk) begin
        if (srst) begin
            errOverrun_q <= 1'b0;
        end else if (beat && (state_q != RUN)) begin
            errOverrun_q <= 1'b1;
        end
    end

    // Frame sequencing: start handshake, crop latch, drain watchdog and frame counting
    always_ff @(posedge clk) begin
        if (srst) begin
            state_q      <= IDLE;
            start_q      <= 1'b0;
            active_q     <= 1'b0;
            cropX0_q     <= '0;
            cropY0_q     <= '0;
            frameCount_q <= '0;
            wd_q         <= '0;
            errTimeout_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (enable && seq_ap_idle) begin
                        state_q <= ARM;
                        start_q <= 1'b1;
                    end
                end
                ARM: begin
                    if (cn_ap_ready) begin
                        cropX0_q <= pendX0_q;
                        cropY0_q <= pendY0_q;
                        start_q  <= 1'b0;
                        active_q <= 1'b1;
                        state_q  <= RUN;
                    end
                end
                RUN: begin
                    wd_q <= '0;
                    if (beat && posLast) begin
                        state_q <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (cn_ap_done) begin
                        frameCount_q <= frameCount_q + 16'd1;
                        wd_q         <= '0;
                        active_q     <= 1'b0;
                        if (enable) begin
                            state_q <= ARM;
                            start_q <= 1'b1;
                        end else begin
                            state_q <= IDLE;
                        end
                    end else if (wdExpire) begin
                        errTimeout_q <= 1'b1;
                        wd_q         <= '0;
                        active_q     <= 1'b0;
                        state_q      <= IDLE;
                    end else begin
                        wd_q <= wd_q + WDW'(1);
                    end
                end
                default: begin
                    state_q  <= IDLE;
                    start_q  <= 1'b0;
                    active_q <= 1'b0;
                end
            endcase
        end
    end

    assign cn_ap_start  = start_q;
    assign crop_x0      = cropX0_q;
    assign crop_y0      = cropY0_q;
    assign frame_active = active_q;
    assign frame_count  = frameCount_q;
    assign err_clamped  = errClamped_q;
    assign err_overrun  = errOverrun_q;
    assign err_timeout  = errTimeout_q;

endmodule

// File: tb/tb_crop_frame_sched.sv
// Directed bench for crop_frame_sched on an 8x8 frame with a 4x4 crop box.
module tb_crop_frame_sched;

    localparam int IN_ROWS      = 8;
    localparam int IN_COLS      = 8;
    localparam int OUT_ROWS     = 4;
    localparam int OUT_COLS     = 4;
    localparam int DONE_TIMEOUT = 16;

    logic        clk = 1'b0;
    logic        srst;
    logic        enable;
    logic [2:0]  cfg_x0;
    logic [2:0]  cfg_y0;
    logic        cfg_valid;
    logic        seq_ap_idle;
    logic        pix_tvalid;
    logic        pix_tready;
    logic        cn_ap_ready;
    logic        cn_ap_done;
    logic        cn_ap_start;
    logic [2:0]  crop_x0;
    logic [2:0]  crop_y0;
    logic [2:0]  cnt_col;
    logic [2:0]  cnt_row;
    logic        frame_active;
    logic [15:0] frame_count;
    logic        err_clamped;
    logic        err_overrun;
    logic        err_timeout;

    int testsRun    = 0;
    int testsFailed = 0;

    crop_frame_sched #(
        .IN_ROWS      (IN_ROWS),
        .IN_COLS      (IN_COLS),
        .OUT_ROWS     (OUT_ROWS),
        .OUT_COLS     (OUT_COLS),
        .DONE_TIMEOUT (DONE_TIMEOUT)
    ) dut (
        .clk          (clk),
        .srst         (srst),
        .enable       (enable),
        .cfg_x0       (cfg_x0),
        .cfg_y0       (cfg_y0),
        .cfg_valid    (cfg_valid),
        .seq_ap_idle  (seq_ap_idle),
        .pix_tvalid   (pix_tvalid),
        .pix_tready   (pix_tready),
        .cn_ap_ready  (cn_ap_ready),
        .cn_ap_done   (cn_ap_done),
        .cn_ap_start  (cn_ap_start),
        .crop_x0      (crop_x0),
        .crop_y0      (crop_y0),
        .cnt_col      (cnt_col),
        .cnt_row      (cnt_row),
        .frame_active (frame_active),
        .frame_count  (frame_count),
        .err_clamped  (err_clamped),
        .err_overrun  (err_overrun),
        .err_timeout  (err_timeout)
    );

    // Free-running 100 MHz clock
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        testsRun++;
        if (observed !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, ".start"},   32'(cn_ap_start),  32'd0);
        checkOutput({tag, ".cropx"},   32'(crop_x0),      32'd0);
        checkOutput({tag, ".cropy"},   32'(crop_y0),      32'd0);
        checkOutput({tag, ".col"},     32'(cnt_col),      32'd0);
        checkOutput({tag, ".row"},     32'(cnt_row),      32'd0);
        checkOutput({tag, ".active"},  32'(frame_active), 32'd0);
        checkOutput({tag, ".fcount"},  32'(frame_count),  32'd0);
        checkOutput({tag, ".clamp"},   32'(err_clamped),  32'd0);
        checkOutput({tag, ".overrun"}, 32'(err_overrun),  32'd0);
        checkOutput({tag, ".timeout"}, 32'(err_timeout),  32'd0);
    endtask

    task automatic setCfg(input int x, input int y);
        cfg_x0    = 3'(x);
        cfg_y0    = 3'(y);
        cfg_valid = 1'b1;
        tick();
        cfg_valid = 1'b0;
    endtask

    // Push n beats with random stall cycles; optionally strobe cfg (1,1) with beat reconfigAt
    task automatic applyStimulus(input int n, input int reconfigAt);
        for (int k = 0; k < n; k++) begin
            int gaps = $urandom_range(0, 2);
            for (int g = 0; g < gaps; g++) begin
                pix_tvalid = g[0];
                pix_tready = ~g[0];
                tick();
            end
            pix_tvalid = 1'b1;
            pix_tready = 1'b1;
            if (k == reconfigAt) begin
                cfg_x0    = 3'd1;
                cfg_y0    = 3'd1;
                cfg_valid = 1'b1;
            end
            tick();
            cfg_valid  = 1'b0;
            pix_tvalid = 1'b0;
            pix_tready = 1'b0;
            checkOutput($sformatf("col@%0d", k), 32'(cnt_col), 32'((k + 1) % IN_COLS));
            checkOutput($sformatf("row@%0d", k), 32'(cnt_row), 32'(((k + 1) / IN_COLS) % IN_ROWS));
        end
    endtask

    initial begin
        srst        = 1'b1;
        enable      = 1'b0;
        cfg_x0      = '0;
        cfg_y0      = '0;
        cfg_valid   = 1'b0;
        seq_ap_idle = 1'b1;
        pix_tvalid  = 1'b0;
        pix_tready  = 1'b0;
        cn_ap_ready = 1'b0;
        cn_ap_done  = 1'b0;

        // Reset and stray beats in IDLE
        repeat (3) tick();
        checkAllZero("reset");
        srst       = 1'b0;
        pix_tvalid = 1'b1;
        pix_tready = 1'b1;
        repeat (2) tick();
        pix_tvalid = 1'b0;
        pix_tready = 1'b0;
        checkOutput("idle.overrun", 32'(err_overrun),  32'd1);
        checkOutput("idle.col",     32'(cnt_col),      32'd0);
        checkOutput("idle.row",     32'(cnt_row),      32'd0);
        checkOutput("idle.active",  32'(frame_active), 32'd0);
        srst = 1'b1;
        tick();
        srst = 1'b0;

        // Single frame with crop (2,3), enable dropped while armed
        setCfg(2, 3);
        checkOutput("f1.noclamp", 32'(err_clamped), 32'd0);
        enable = 1'b1;
        tick();
        checkOutput("f1.arm.start",  32'(cn_ap_start),  32'd1);
        checkOutput("f1.arm.active", 32'(frame_active), 32'd0);
        enable = 1'b0;
        repeat (2) tick();
        checkOutput("f1.arm.held", 32'(cn_ap_start), 32'd1);
        cn_ap_ready = 1'b1;
        tick();
        cn_ap_ready = 1'b0;
        checkOutput("f1.cropx",  32'(crop_x0),      32'd2);
        checkOutput("f1.cropy",  32'(crop_y0),      32'd3);
        checkOutput("f1.start0", 32'(cn_ap_start),  32'd0);
        checkOutput("f1.run",    32'(frame_active), 32'd1);
        applyStimulus(64, -1);
        checkOutput("f1.drain", 32'(frame_active), 32'd1);
        repeat (4) tick();
        cn_ap_done = 1'b1;
        tick();
        cn_ap_done = 1'b0;
        checkOutput("f1.fcount",  32'(frame_count),  32'd1);
        checkOutput("f1.idle",    32'(frame_active), 32'd0);
        checkOutput("f1.nostart", 32'(cn_ap_start),  32'd0);
        checkOutput("f1.overrun", 32'(err_overrun),  32'd0);
        checkOutput("f1.timeout", 32'(err_timeout),  32'd0);
        cn_ap_done = 1'b1;
        tick();
        cn_ap_done = 1'b0;
        tick();
        checkOutput("idle.doneignored", 32'(frame_count), 32'd1);
        checkOutput("idle.stays",       32'(cn_ap_start), 32'd0);

        // Clamped cfg, then a mid-frame reconfig to (1,1)
        setCfg(7, 1);
        checkOutput("clamp.flag", 32'(err_clamped), 32'd1);
        enable = 1'b1;
        tick();
        cn_ap_ready = 1'b1;
        tick();
        cn_ap_ready = 1'b0;
        checkOutput("clamp.cropx", 32'(crop_x0), 32'd4);
        checkOutput("clamp.cropy", 32'(crop_y0), 32'd1);
        applyStimulus(64, 10);
        checkOutput("reconf.keepx", 32'(crop_x0), 32'd4);
        checkOutput("reconf.keepy", 32'(crop_y0), 32'd1);
        tick();
        cn_ap_done = 1'b1;
        tick();
        cn_ap_done = 1'b0;
        checkOutput("reconf.fcount", 32'(frame_count), 32'd2);
        checkOutput("reconf.rearm",  32'(cn_ap_start), 32'd1);

        // Next frame uses (1,1); a cfg strobe on the handshake waits for the frame after
        cn_ap_ready = 1'b1;
        cfg_x0      = 3'd3;
        cfg_y0      = 3'd3;
        cfg_valid   = 1'b1;
        tick();
        cn_ap_ready = 1'b0;
        cfg_valid   = 1'b0;
        enable      = 1'b0;
        checkOutput("f2.cropx", 32'(crop_x0), 32'd1);
        checkOutput("f2.cropy", 32'(crop_y0), 32'd1);
        applyStimulus(64, -1);

        // No ap_done: watchdog fires exactly 16 cycles after entering DRAIN
        repeat (15) tick();
        checkOutput("wd.early",       32'(err_timeout),  32'd0);
        checkOutput("wd.earlyactive", 32'(frame_active), 32'd1);
        tick();
        checkOutput("wd.fire",   32'(err_timeout),  32'd1);
        checkOutput("wd.idle",   32'(frame_active), 32'd0);
        checkOutput("wd.fcount", 32'(frame_count),  32'd2);
        checkOutput("wd.start",  32'(cn_ap_start),  32'd0);

        // Frame with the deferred (3,3), aborted by reset after 30 beats
        enable = 1'b1;
        tick();
        cn_ap_ready = 1'b1;
        tick();
        cn_ap_ready = 1'b0;
        checkOutput("f3.cropx", 32'(crop_x0), 32'd3);
        checkOutput("f3.cropy", 32'(crop_y0), 32'd3);
        applyStimulus(30, -1);
        srst = 1'b1;
        tick();
        checkAllZero("abort");
        tick();
        checkOutput("abort.nostart", 32'(cn_ap_start), 32'd0);
        srst = 1'b0;
        tick();
        checkOutput("restart.start", 32'(cn_ap_start), 32'd1);
        cn_ap_ready = 1'b1;
        tick();
        cn_ap_ready = 1'b0;
        checkOutput("restart.cropx",  32'(crop_x0),      32'd0);
        checkOutput("restart.cropy",  32'(crop_y0),      32'd0);
        checkOutput("restart.active", 32'(frame_active), 32'd1);
        applyStimulus(64, -1);
        enable = 1'b0;
        tick();
        cn_ap_done = 1'b1;
        tick();
        cn_ap_done = 1'b0;
        checkOutput("restart.fcount",  32'(frame_count),  32'd1);
        checkOutput("restart.overrun", 32'(err_overrun),  32'd0);
        checkOutput("restart.clamp",   32'(err_clamped),  32'd0);
        checkOutput("restart.timeout", 32'(err_timeout),  32'd0);
        checkOutput("restart.idle",    32'(frame_active), 32'd0);
        checkOutput("restart.nostart", 32'(cn_ap_start),  32'd0);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
